alu_issue: RTL and testbench
============================

# alu_issue

- Pipelined issue stage that drives the 32-bit ALU.
- Decodes RV32I `opcode`/`funct3`/`funct7[5]` into the 6-bit ALU control encoding and selects the A and B operands.
- Registers the result behind a 2-entry skid buffer with valid/ready on both sides.
- Sits between register-file read and the execute stage, so the ALU sees only registered, fully decoded inputs.

## Interface
Parameters:
- `XLEN`, 32, operand/PC width.

Ports (clock and reset first):
- `clk`  in  1  — core clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `flush`  in  1  — discard all held entries (branch redirect).
- `in_valid`  in  1  — upstream holds a valid instruction.
- `in_ready`  out  1  — stage can accept this cycle (registered).
- `in_instr`  in  32  — raw instruction; uses bits [6:0], [14:12], [30].
- `in_pc`  in  XLEN  — instruction PC.
- `in_rs1`  in  XLEN  — rs1 value.
- `in_rs2`  in  XLEN  — rs2 value.
- `in_imm`  in  XLEN  — sign-extended immediate, pre-formatted (U-type already shifted).
- `out_valid`  out  1  — issued op valid.
- `out_ready`  in  1  — execute accepts.
- `out_a`, `out_b`  out  XLEN  — ALU operands A, B.
- `out_alu_ctrl`  out  6  — ALU control code.
- `out_pc`  out  XLEN  — forwarded PC.
- `out_is_branch`  out  1  — conditional branch; execute uses ALU `Zero` as taken.
- `out_illegal`  out  1  — unsupported opcode/funct3.

## Operation
ALU control codes:
- ADD 000000, SUB/BEQ 000001, AND 000010, OR 000011, XOR 000100
- SLT/BLT 000101, SLL 000110, PASSB 000111, SRL 001000, SRA 001001
- SLTU/BLTU 001010, BNE 001011, BGE 001100, BGEU 001101

Decode:
- OP (0110011), A=rs1, B=rs2:
  - funct3 000 → ADD, or SUB if bit30=1
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
  - 101 → SRL, or SRA if bit30=1
  - 110 → OR; 111 → AND
- OP-IMM (0010011), A=rs1, B=imm: same mapping, except funct3 000 is always ADD. SRA selection uses bit30.
- LUI (0110111): B=imm, PASSB, A=0.
- AUIPC (0010111): A=pc, B=imm, ADD.
- LOAD (0000011) / STORE (0100011): A=rs1, B=imm, ADD.
- BRANCH (1100011): A=rs1, B=rs2, `is_branch`=1.
  - funct3 000 → BEQ; 001 → BNE; 100 → BLT; 101 → BGE; 110 → BLTU; 111 → BGEU
  - 010/011 → illegal
- JAL (1101111) / JALR (1100111): A=pc, B=4, ADD (link value).
- Any other opcode: `illegal`=1, ctrl=ADD, A=B=0, `is_branch`=0.

Buffer:
- Main register drives the outputs; a skid register holds one overflow entry.
- Occupancy states:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept with `out_valid && !out_ready`.
  - ONE → EMPTY on drain with no accept; ONE → ONE on simultaneous accept and drain.
  - TWO → ONE on drain; skid moves into main.
- Accept = `in_valid && in_ready`. Drain = `out_valid && out_ready`.
- `in_ready` = 1 in EMPTY/ONE, 0 in TWO, computed from next-state and registered.
- Order is strictly FIFO; an entry is never dropped or duplicated.
- Flush has priority over accept and drain:
  - Next state EMPTY; an input accepted in the flush cycle is discarded.
  - Output data registers are not required to clear.

## Timing
- Reset (`rst`=0 at edge): `out_valid`=0, `in_ready`=1; all data outputs, `out_is_branch` and `out_illegal` = 0; state EMPTY.
- Reset overrides flush and any in-flight handshake.
- Latency: input accepted at edge N appears on the outputs after edge N, i.e. `out_valid`=1 in cycle N+1.
- Throughput: one op per cycle while `out_ready`=1.
- Outputs hold stable while `out_valid && !out_ready`.
- After TWO drains to ONE, `in_ready` returns to 1 the following cycle.
- `in_ready` combinationally independent of `out_ready`.
- `in_valid` while `in_ready`=0: ignored; upstream must hold.

## Configuration
- `ALU_ISSUE_SHAMT_MASK_EN` defined: for SLL/SRL/SRA, `out_b[XLEN-1:5]` forced to 0, so the shift amount is rs2[4:0]/imm[4:0] per ISA.
- Undefined: B passed unmasked. The ALU then shifts by the full B; software must keep the amount < 32.

## Structure
- Package `alu_pkg`:
  - ALU control code localparams (names above)
  - RV32I opcode constants
  - A-select enum (RS1, PC, ZERO) and B-select enum (RS2, IMM, FOUR)
  - Shared with the ALU and the control unit.
- Sub-module `alu_ctrl_decode`: purely combinational decoder (instr → ctrl, a_sel, b_sel, is_branch, illegal). `alu_issue` adds operand muxes and the skid buffer.

## Test plan
- R-type SUB (instr 0x40B50533, rs1=7, rs2=3), `out_ready`=1 → next cycle `out_valid`=1, ctrl=000001, A=7, B=3.
- SRAI (instr 0x40355513, imm=0x403, rs1=0x80000000):
  - Macro defined → ctrl=001001, B=3.
  - Macro undefined → B=0x403.
- BGEU (funct3 111) → ctrl=001101, `is_branch`=1. Funct3 010 branch → `illegal`=1, ctrl=000000.
- Backpressure: `out_ready`=0, three back-to-back valids.
  - First two accepted; `in_ready`=0 from cycle 2.
  - Raise `out_ready` → outputs in order 1, 2; third accepted one cycle after drain.
- Flush in TWO with a concurrent `in_valid` → next cycle `out_valid`=0, `in_ready`=1; no stale op appears.
- Reset mid-stream in TWO → all outputs 0, `in_ready`=1 on the following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV32I opcodes, operand-select enums.
// Used by the ALU, the control decoder and the issue stage.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_BEQ   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b000010;
  localparam logic [5:0] ALU_OR    = 6'b000011;
  localparam logic [5:0] ALU_XOR   = 6'b000100;
  localparam logic [5:0] ALU_SLT   = 6'b000101;
  localparam logic [5:0] ALU_BLT   = 6'b000101;
  localparam logic [5:0] ALU_SLL   = 6'b000110;
  localparam logic [5:0] ALU_PASSB = 6'b000111;
  localparam logic [5:0] ALU_SRL   = 6'b001000;
  localparam logic [5:0] ALU_SRA   = 6'b001001;
  localparam logic [5:0] ALU_SLTU  = 6'b001010;
  localparam logic [5:0] ALU_BLTU  = 6'b001010;
  localparam logic [5:0] ALU_BNE   = 6'b001011;
  localparam logic [5:0] ALU_BGE   = 6'b001100;
  localparam logic [5:0] ALU_BGEU  = 6'b001101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {ASEL_RS1, ASEL_PC, ASEL_ZERO} a_sel_e;
  typedef enum logic [1:0] {BSEL_RS2, BSEL_IMM, BSEL_FOUR} b_sel_e;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;

  function automatic logic is_shift_ctrl(input logic [5:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream and downstream handshake bundle of the ALU issue stage.
interface alu_issue_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [5:0]      out_alu_ctrl;
  logic [XLEN-1:0] out_pc;
  logic            out_is_branch;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_pc,
           out_is_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_pc,
           out_is_branch, out_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decoder: instruction -> ALU control, operand selects, flags.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  ctrl_o,
  output a_sel_e      a_sel_o,
  output b_sel_e      b_sel_o,
  output logic        is_branch_o,
  output logic        illegal_o
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign alt          = instr_i[30];
  assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  // OP-IMM never encodes SUB, so the caller masks alt for funct3 000.
  function automatic logic [5:0] arith_ctrl(input logic [2:0] f3, input logic sub, input logic sra);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return sra ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl_o      = ALU_ADD;
    a_sel_o     = ASEL_ZERO;
    b_sel_o     = BSEL_RS2;
    is_branch_o = 1'b0;
    illegal_o   = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_sel_o = ASEL_RS1;
        ctrl_o  = arith_ctrl(funct3, alt, alt);
      end
      OPC_OP_IMM: begin
        a_sel_o = ASEL_RS1;
        b_sel_o = BSEL_IMM;
        ctrl_o  = arith_ctrl(funct3, 1'b0, alt);
      end
      OPC_LUI: begin
        b_sel_o = BSEL_IMM;
        ctrl_o  = ALU_PASSB;
      end
      OPC_AUIPC: begin
        a_sel_o = ASEL_PC;
        b_sel_o = BSEL_IMM;
      end
      OPC_LOAD, OPC_STORE: begin
        a_sel_o = ASEL_RS1;
        b_sel_o = BSEL_IMM;
      end
      OPC_BRANCH: begin
        a_sel_o     = ASEL_RS1;
        is_branch_o = 1'b1;
        case (funct3)
          3'b000:  ctrl_o = ALU_BEQ;
          3'b001:  ctrl_o = ALU_BNE;
          3'b100:  ctrl_o = ALU_BLT;
          3'b101:  ctrl_o = ALU_BGE;
          3'b110:  ctrl_o = ALU_BLTU;
          3'b111:  ctrl_o = ALU_BGEU;
          default: begin
            a_sel_o     = ASEL_ZERO;
            is_branch_o = 1'b0;
            illegal_o   = 1'b1;
          end
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        a_sel_o = ASEL_PC;
        b_sel_o = BSEL_FOUR;
      end
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode, operand select, 2-entry skid buffer toward execute.
// Optional macro ALU_ISSUE_SHAMT_MASK_EN clears out_b[XLEN-1:5] for shifts.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  alu_issue_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [5:0]      ctrl;
    logic [XLEN-1:0] pc;
    logic            is_branch;
    logic            illegal;
  } entry_t;

  logic [5:0] dec_ctrl;
  a_sel_e     dec_a_sel;
  b_sel_e     dec_b_sel;
  logic       dec_branch;
  logic       dec_illegal;
  entry_t     new_entry;

  alu_ctrl_decode u_dec (
    .instr_i     (bus.in_instr),
    .ctrl_o      (dec_ctrl),
    .a_sel_o     (dec_a_sel),
    .b_sel_o     (dec_b_sel),
    .is_branch_o (dec_branch),
    .illegal_o   (dec_illegal)
  );

  always_comb begin
    new_entry           = '0;
    new_entry.ctrl      = dec_ctrl;
    new_entry.pc        = bus.in_pc;
    new_entry.is_branch = dec_branch;
    new_entry.illegal   = dec_illegal;
    case (dec_a_sel)
      ASEL_RS1: new_entry.a = bus.in_rs1;
      ASEL_PC:  new_entry.a = bus.in_pc;
      default:  new_entry.a = '0;
    endcase
    case (dec_b_sel)
      BSEL_RS2: new_entry.b = bus.in_rs2;
      BSEL_IMM: new_entry.b = bus.in_imm;
      default:  new_entry.b = XLEN'(4);
    endcase
    if (dec_illegal) new_entry.b = '0;
`ifdef ALU_ISSUE_SHAMT_MASK_EN
    if (is_shift_ctrl(dec_ctrl)) new_entry.b[XLEN-1:5] = '0;
`endif
  end

  occ_e   state_q, state_d;
  entry_t main_q, skid_q;
  logic   in_ready_q;
  logic   out_valid;
  logic   accept, drain;

  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = bus.in_valid && in_ready_q;
  assign drain     = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (accept) state_d = OCC_ONE;
      OCC_ONE: begin
        if (accept && !drain) state_d = OCC_TWO;
        else if (!accept && drain) state_d = OCC_EMPTY;
      end
      OCC_TWO: if (drain) state_d = OCC_ONE;
      default: state_d = OCC_EMPTY;
    endcase
    if (flush) state_d = OCC_EMPTY;
  end

  // Data moves only without flush; a flushed accept is simply never loaded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_TWO);
      if (!flush) begin
        case (state_q)
          OCC_EMPTY: if (accept) main_q <= new_entry;
          OCC_ONE: begin
            if (accept && drain) main_q <= new_entry;
            else if (accept) skid_q <= new_entry;
          end
          OCC_TWO: if (drain) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid;
  assign bus.out_a         = main_q.a;
  assign bus.out_b         = main_q.b;
  assign bus.out_alu_ctrl  = main_q.ctrl;
  assign bus.out_pc        = main_q.pc;
  assign bus.out_is_branch = main_q.is_branch;
  assign bus.out_illegal   = main_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode table, buffering, flush, reset.
module tb_alu_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.XLEN(32)) bus ();

  alu_issue #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2, imm;
    logic [5:0]  ctrl;
    logic [31:0] a, b;
    logic        br, ill;
  } vec_t;

  localparam logic [31:0] I_LW = 32'h0000_2003;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, pc, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic test_reset();
    logic [104:0] got;
    rst = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    drive(32'h0000_0033, 32'h44, 32'h1, 32'h2, 32'h3);
    tick(); tick();
    got = {bus.out_valid, bus.in_ready, bus.out_alu_ctrl, bus.out_a, bus.out_b,
           bus.out_pc, bus.out_is_branch};
    checks++;
    if (got !== {1'b0, 1'b1, 6'd0, 96'd0, 1'b0} || bus.out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%h ill=%b exp=%h ill=0", got, bus.out_illegal,
               {1'b0, 1'b1, 6'd0, 96'd0, 1'b0});
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_decode();
    vec_t vs[$];
    logic [104:0] got, exp;
    logic [31:0]  srai_b;
`ifdef ALU_ISSUE_SHAMT_MASK_EN
    srai_b = 32'h3;
`else
    srai_b = 32'h403;
`endif
    vs.push_back('{"sub",     32'h40B5_0533, 32'h100, 32'd7, 32'd3, 32'h55, ALU_SUB, 32'd7, 32'd3, 1'b0, 1'b0});
    vs.push_back('{"srai",    32'h4035_5513, 32'h104, 32'h8000_0000, 32'h9, 32'h403, ALU_SRA, 32'h8000_0000, srai_b, 1'b0, 1'b0});
    vs.push_back('{"bgeu",    32'h0000_7063, 32'h108, 32'd5, 32'd6, 32'h20, ALU_BGEU, 32'd5, 32'd6, 1'b1, 1'b0});
    vs.push_back('{"br_f3_2", 32'h0000_2063, 32'h10C, 32'd5, 32'd6, 32'h20, ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1});
    vs.push_back('{"lui",     32'h0000_0037, 32'h110, 32'd9, 32'd8, 32'h1234_5000, ALU_PASSB, 32'd0, 32'h1234_5000, 1'b0, 1'b0});
    vs.push_back('{"auipc",   32'h0000_0017, 32'h114, 32'd9, 32'd8, 32'h0000_1000, ALU_ADD, 32'h114, 32'h1000, 1'b0, 1'b0});
    vs.push_back('{"jal",     32'h0000_006F, 32'h118, 32'd9, 32'd8, 32'h0000_0800, ALU_ADD, 32'h118, 32'd4, 1'b0, 1'b0});
    vs.push_back('{"addi_b30",32'h4000_0013, 32'h11C, 32'd10, 32'd8, 32'hFFFF_FC00, ALU_ADD, 32'd10, 32'hFFFF_FC00, 1'b0, 1'b0});
    vs.push_back('{"or",      32'h0000_6033, 32'h120, 32'hF0, 32'h0F, 32'h1, ALU_OR, 32'hF0, 32'h0F, 1'b0, 1'b0});
    vs.push_back('{"bad_opc", 32'h0000_007F, 32'h124, 32'd5, 32'd6, 32'd7, ALU_ADD, 32'd0, 32'd0, 1'b0, 1'b1});
    vs.push_back('{"sw",      32'h0000_2023, 32'h128, 32'h1000, 32'h77, 32'h10, ALU_ADD, 32'h1000, 32'h10, 1'b0, 1'b0});
    vs.push_back('{"sltu",    32'h0000_3033, 32'h12C, 32'd1, 32'd2, 32'd3, ALU_SLTU, 32'd1, 32'd2, 1'b0, 1'b0});
    vs.push_back('{"jalr",    32'h0000_0067, 32'h130, 32'd1, 32'd2, 32'd3, ALU_ADD, 32'h130, 32'd4, 1'b0, 1'b0});
    bus.out_ready = 1'b1;
    foreach (vs[i]) begin
      drive(vs[i].instr, vs[i].pc, vs[i].rs1, vs[i].rs2, vs[i].imm);
      tick();
      bus.in_valid = 1'b0;
      got = {bus.out_valid, bus.out_alu_ctrl, bus.out_a, bus.out_b, bus.out_pc,
             bus.out_is_branch, bus.out_illegal};
      exp = {1'b1, vs[i].ctrl, vs[i].a, vs[i].b, vs[i].pc, vs[i].br, vs[i].ill};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL decode_%s got=%h exp=%h", vs[i].name, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int unsigned t = 1; t <= 3; t++) begin
      drive(I_LW, 32'h200, t, 32'd0, 32'd0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_a !== t || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d got v=%b a=%h rdy=%b exp v=1 a=%h rdy=1",
                 t, bus.out_valid, bus.out_a, bus.in_ready, t);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drained got v=%b exp v=0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(I_LW, 32'h300, 32'd1, 32'd0, 32'd0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd1 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first got v=%b a=%h rdy=%b exp v=1 a=1 rdy=1", bus.out_valid, bus.out_a, bus.in_ready);
    end
    drive(I_LW, 32'h300, 32'd2, 32'd0, 32'd0);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_a !== 32'd1) begin
      failures++;
      $display("FAIL bp_full got rdy=%b a=%h exp rdy=0 a=1", bus.in_ready, bus.out_a);
    end
    drive(I_LW, 32'h300, 32'd3, 32'd0, 32'd0);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_a !== 32'd1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got v=%b rdy=%b a=%h exp v=1 rdy=0 a=1", bus.out_valid, bus.in_ready, bus.out_a);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd2 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain1 got v=%b a=%h rdy=%b exp v=1 a=2 rdy=1", bus.out_valid, bus.out_a, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd3) begin
      failures++;
      $display("FAIL bp_third got v=%b a=%h exp v=1 a=3", bus.out_valid, bus.out_a);
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got v=%b exp v=0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(I_LW, 32'h400, 32'h11, 32'd0, 32'd0);
    tick();
    drive(I_LW, 32'h400, 32'h12, 32'd0, 32'd0);
    tick();
    flush = 1'b1;
    drive(I_LW, 32'h400, 32'h13, 32'd0, 32'd0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_two got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stale got v=%b a=%h exp v=0", bus.out_valid, bus.out_a);
    end
    bus.out_ready = 1'b0;
    drive(I_LW, 32'h400, 32'h21, 32'd0, 32'd0);
    tick();
    flush = 1'b1;
    drive(I_LW, 32'h400, 32'h22, 32'd0, 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_accept got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard got v=%b a=%h exp v=0", bus.out_valid, bus.out_a);
    end
  endtask

  task automatic test_reset_midstream();
    logic [104:0] got;
    bus.out_ready = 1'b0;
    drive(32'h0000_7063, 32'h500, 32'h31, 32'h32, 32'd0);
    tick();
    drive(32'h0000_007F, 32'h504, 32'h33, 32'h34, 32'd0);
    tick();
    rst = 1'b0;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    got = {bus.out_valid, bus.in_ready, bus.out_alu_ctrl, bus.out_a, bus.out_b,
           bus.out_pc, bus.out_is_branch};
    checks++;
    if (got !== {1'b0, 1'b1, 6'd0, 96'd0, 1'b0} || bus.out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h ill=%b exp=%h ill=0", got, bus.out_illegal,
               {1'b0, 1'b1, 6'd0, 96'd0, 1'b0});
    end
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_after got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
